stair_seq_checker: RTL and testbench



---
 rtl/stair_seq_checker.sv | 135 +++++++++++++
 tb/tb_stair_seq_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stair_seq_checker.sv
// stair_seq_checker: receive-side checker for the staircase count stream
// 1, 1,2, 1,2,3, ... 1..MAXK, repeating. It acquires alignment from an
// unknown phase (HUNT -> SYNC -> LOCK) and then flags every deviation.
`timescale 1ns/1ps
module stair_seq_checker #(
   parameter int unsigned W    = 3,
   parameter int unsigned MAXK = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] count,
   output logic         locked,
   output logic         err,
   output logic [7:0]   err_cnt,
   output logic         wrap,
   output logic [W-1:0] exp_val
);

   localparam logic [W-1:0] ONE_W  = W'(1);
   localparam logic [W:0]   ONE_X  = (W+1)'(1);
   localparam logic [W-1:0] MAXK_W = W'(MAXK);
   localparam logic [W:0]   MAXK_X = (W+1)'(MAXK);
   localparam logic [7:0]   CNT_MAX = 8'hFF;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      SYNC = 2'd1,
      LOCK = 2'd2
   } state_t;

   state_t       state, state_d;
   logic [W-1:0] cur, cur_d;
   logic [W-1:0] top, top_d;
   logic         err_d, wrap_d, locked_d;
   logic [7:0]   err_cnt_d;
   logic [W-1:0] exp_val_d;
   logic [W-1:0] exp_now;
   logic [W:0]   cur_inc;

   // Length of the ramp following one of length x; MAXK rolls back to 1.
   function automatic logic [W-1:0] next_len(input logic [W-1:0] x);
      logic [W:0] s;
      s = {1'b0, x} + ONE_X;
      return (x == MAXK_W) ? ONE_W : s[W-1:0];
   endfunction

   // Value expected after c inside a ramp of length t.
   function automatic logic [W-1:0] exp_of(input logic [W-1:0] c, input logic [W-1:0] t);
      logic [W:0] s;
      s = {1'b0, c} + ONE_X;
      return (c == t) ? ONE_W : s[W-1:0];
   endfunction

   // State, ramp tracking and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= HUNT;
         cur     <= '0;
         top     <= '0;
         locked  <= 1'b0;
         err     <= 1'b0;
         wrap    <= 1'b0;
         err_cnt <= '0;
         exp_val <= '0;
      end else begin
         state   <= state_d;
         cur     <= cur_d;
         top     <= top_d;
         locked  <= locked_d;
         err     <= err_d;
         wrap    <= wrap_d;
         err_cnt <= err_cnt_d;
         exp_val <= exp_val_d;
      end
   end

   // Next-state, ramp update and output decode for one sample.
   always_comb begin
      state_d   = state;
      cur_d     = cur;
      top_d     = top;
      err_d     = 1'b0;
      wrap_d    = 1'b0;
      err_cnt_d = err_cnt;
      exp_now   = exp_of(cur, top);
      cur_inc   = {1'b0, cur} + ONE_X;

      if (in_valid) begin
         case (state)
            HUNT: begin
               if (count == ONE_W) begin
                  state_d = SYNC;
                  cur_d   = ONE_W;
               end
            end
            SYNC: begin
               // Extended-width compare so cur+1 cannot alias onto a legal value.
               if (({1'b0, count} == cur_inc) && (cur_inc <= MAXK_X)) begin
                  cur_d = cur_inc[W-1:0];
               end else if (count == ONE_W) begin
                  top_d   = next_len(cur);
                  cur_d   = ONE_W;
                  state_d = LOCK;
               end else begin
                  state_d = HUNT;
               end
            end
            LOCK: begin
               if (count == exp_now) begin
                  cur_d = exp_now;
                  if (exp_now == ONE_W) begin
                     top_d  = next_len(top);
                     wrap_d = (top == MAXK_W);
                  end
               end else begin
                  err_d     = 1'b1;
                  err_cnt_d = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + 8'd1;
                  if (count == ONE_W) begin
                     state_d = SYNC;
                     cur_d   = ONE_W;
                  end else begin
                     state_d = HUNT;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end

      locked_d  = (state_d == LOCK);
      exp_val_d = locked_d ? exp_of(cur_d, top_d) : '0;
   end

endmodule

// File: tb/tb_stair_seq_checker.sv
// Testbench for stair_seq_checker: randomized and directed staircase streams
// checked through a scoreboard against a position-in-super-cycle model.
`timescale 1ns/1ps
module tb_stair_seq_checker;

   localparam int W    = 3;
   localparam int MAXK = 7;
   localparam int L    = MAXK * (MAXK + 1) / 2;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] count = '0;
   logic         locked, err, wrap;
   logic [7:0]   err_cnt;
   logic [W-1:0] exp_val;

   stair_seq_checker #(.W(W), .MAXK(MAXK)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .count    (count),
      .locked   (locked),
      .err      (err),
      .err_cnt  (err_cnt),
      .wrap     (wrap),
      .exp_val  (exp_val)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lk;
      int er;
      int wr;
      int cnt;
      int ev;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference: the legal stream as a table; lock is a position within it.
   int seq[L];
   int mode;   // 0 hunt, 1 sync, 2 lock
   int run;    // sync: last value of the ramp being learned
   int pos;    // lock: index of last accepted sample in seq
   int errc;
   int m_err, m_wrap;
   int gpos;   // generator position in the clean stream

   function automatic int ramp_start(input int k);
      return (k - 1) * k / 2;
   endfunction

   function automatic void model_reset();
      mode = 0; run = 0; pos = 0; errc = 0; m_err = 0; m_wrap = 0;
   endfunction

   function automatic void model_step(input int vld, input int v);
      int e;
      m_err = 0;
      m_wrap = 0;
      if (vld == 0) return;
      if (mode == 0) begin
         if (v == 1) begin mode = 1; run = 1; end
      end else if (mode == 1) begin
         if (v == run + 1 && run + 1 <= MAXK) run = run + 1;
         else if (v == 1) begin
            mode = 2;
            pos = ramp_start((run == MAXK) ? 1 : run + 1);
         end else mode = 0;
      end else begin
         e = seq[(pos + 1) % L];
         if (v == e) begin
            pos = (pos + 1) % L;
            m_wrap = (pos == 0) ? 1 : 0;
         end else begin
            m_err = 1;
            if (errc < 255) errc = errc + 1;
            if (v == 1) begin mode = 1; run = 1; end
            else mode = 0;
         end
      end
   endfunction

   function automatic void push_expect();
      exp_t x;
      x.lk  = (mode == 2) ? 1 : 0;
      x.er  = m_err;
      x.wr  = m_wrap;
      x.cnt = errc;
      x.ev  = (mode == 2) ? seq[(pos + 1) % L] : 0;
      sbq.push_back(x);
   endfunction

   function automatic void chk(input string nm, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, want);
      end
   endfunction

   // Monitor: outputs for each captured cycle are compared mid-period.
   always @(negedge clk) begin
      exp_t x;
      if (sbq.size() != 0) begin
         x = sbq.pop_front();
         chk("locked",  int'(locked),  x.lk);
         chk("err",     int'(err),     x.er);
         chk("wrap",    int'(wrap),    x.wr);
         chk("err_cnt", int'(err_cnt), x.cnt);
         chk("exp_val", int'(exp_val), x.ev);
      end
   end

   task automatic send(input int vld, input int v);
      @(negedge clk);
      in_valid = (vld != 0);
      count    = W'(v);
      @(posedge clk);
      model_step(vld, v);
      push_expect();
   endtask

   // Clean stream with optional gaps and random corruption (percent).
   task automatic stream(input int n, input int gap_pct, input int bad_pct);
      int v;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(99) < gap_pct) begin
            send(0, $urandom_range(7));
         end else begin
            v = seq[gpos];
            if ($urandom_range(99) < bad_pct) v = $urandom_range(7);
            send(1, v);
            gpos = (gpos + 1) % L;
         end
      end
   endtask

   task automatic advance_to(input int p);
      for (int i = 0; i < L && gpos != p; i++) stream(1, 0, 0);
   endtask

   function automatic void chk_zero();
      chk("rst_locked",  int'(locked),  0);
      chk("rst_err",     int'(err),     0);
      chk("rst_wrap",    int'(wrap),    0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      chk("rst_exp_val", int'(exp_val), 0);
   endfunction

   // Short reset pulse between clock edges; outputs must clear at once.
   task automatic pulse_reset();
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #0.5 chk_zero();
      #0.5 rst = 1'b1;
      model_reset();
   endtask

   initial begin
      int k;
      k = 0;
      for (int r = 1; r <= MAXK; r++)
         for (int j = 1; j <= r; j++) begin seq[k] = j; k++; end
      model_reset();

      #12 chk_zero();
      #1 rst = 1'b1;

      // Clean stream, 85 samples: lock after sample 2, wraps at 29/57/85.
      gpos = 0;
      stream(85, 0, 0);

      // Join at sample 3 of ramp 5.
      pulse_reset();
      gpos = ramp_start(5) + 2;
      stream(40, 0, 0);

      // Replace the 4 in ramp 5 with 6.
      advance_to(ramp_start(5) + 3);
      send(1, 6);
      gpos = gpos + 1;
      stream(60, 0, 0);

      // Inject 1 in place of 3 in ramp 6.
      advance_to(ramp_start(6) + 2);
      send(1, 1);
      gpos = gpos + 1;
      stream(60, 0, 0);

      // Clean stream with ~50% valid duty, then with random corruption.
      stream(200, 50, 0);
      stream(400, 30, 4);

      // Three mismatches, then reset mid-LOCK and relock.
      pulse_reset();
      gpos = 0;
      stream(10, 0, 0);
      for (int i = 0; i < 3; i++) begin
         send(1, 0);
         stream(30, 0, 0);
      end
      pulse_reset();
      gpos = 0;
      stream(30, 0, 0);

      // 260 forced mismatches saturate err_cnt.
      for (int i = 0; i < 260; i++) begin
         send(1, 1);
         send(1, 1);
         send(1, 3);
      end
      send(0, 0);

      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
      #1;
      if (sbq.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
